// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares the single memory port between the instruction-fetch requester and
// the data-memory requester. One transaction is in flight at a time: a grant
// latches the request fields into the mem_* registers, mem_enable strobes for
// one cycle, the arbiter waits for mem_valid (or a watchdog timeout), and the
// owner then receives a one-cycle ready pulse with its captured read data.
// Data has priority over fetch, except that after STARVE_MAX consecutive
// data grants with fetch waiting, the next grant goes to fetch.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   i_req/i_addr                  fetch request and address
//   i_rdata/i_ready               fetch read data and completion pulse
//   d_req/d_cmd/d_addr/d_mask/d_wdata
//                                 data request, command (1 = write), address,
//                                 byte mask and store data
//   d_rdata/d_ready               load data and completion pulse
//   mem_enable/mem_cmd/mem_addr/mem_mask/mem_write_data
//                                 memory-side issue strobe and request fields
//   mem_load_data/mem_valid       memory read data and completion
//   stall_if/stall_mem            pipeline stalls (combinational)
//   err                           sticky watchdog timeout flag
module mem_port_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ready,
  input  logic        d_req,
  input  logic        d_cmd,
  input  logic [31:0] d_addr,
  input  logic [3:0]  d_mask,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic        mem_enable,
  output logic        mem_cmd,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_mask,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_load_data,
  input  logic        mem_valid,
  output logic        stall_if,
  output logic        stall_mem,
  output logic        err
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
  // Count value held during the last permitted WAIT cycle; the timeout fires
  // in the cycle that would bring the count up to TIMEOUT.
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic            r_owner;   // 0 = fetch, 1 = data
  logic [SW-1:0]   r_starve;
  logic [TW-1:0]   r_tcnt;
  logic            r_err;
  logic            r_i_ready;
  logic            r_d_ready;
  logic [31:0]     r_i_rdata;
  logic [31:0]     r_d_rdata;
  logic            r_mem_enable;
  logic            r_mem_cmd;
  logic [31:0]     r_mem_addr;
  logic [3:0]      r_mem_mask;
  logic [31:0]     r_mem_wdata;

  logic            w_grant;
  logic            w_grant_d;
  logic            w_done;
  logic            w_tmo;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state, arbitration and completion decode
  always_comb begin
    w_next    = r_state;
    w_grant   = 1'b0;
    w_grant_d = 1'b0;
    w_done    = 1'b0;
    w_tmo     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_req || d_req) begin
          w_grant   = 1'b1;
          // Data wins a tie unless fetch has been passed over too often.
          w_grant_d = d_req && !(i_req && (r_starve == STARVE_LIM));
          w_next    = S_ISSUE;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_ISSUE: begin
        w_next = S_WAIT;
      end
      S_WAIT: begin
        // A valid arriving in the timeout cycle takes precedence.
        if (mem_valid) begin
          w_done = 1'b1;
          w_next = S_RESP;
        end else if (r_tcnt == TMO_LAST) begin
          w_tmo  = 1'b1;
          w_next = S_RESP;
        end else begin
          w_next = S_WAIT;
        end
      end
      S_RESP: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Grant capture: owner, issue strobe and latched memory request fields
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner      <= 1'b0;
      r_mem_enable <= 1'b0;
      r_mem_cmd    <= 1'b0;
      r_mem_addr   <= 32'h0;
      r_mem_mask   <= 4'h0;
      r_mem_wdata  <= 32'h0;
    end else begin
      r_mem_enable <= w_grant;
      if (w_grant) begin
        r_owner <= w_grant_d;
        if (w_grant_d) begin
          r_mem_cmd   <= d_cmd;
          r_mem_addr  <= d_addr;
          r_mem_mask  <= d_mask;
          r_mem_wdata <= d_wdata;
        end else begin
          r_mem_cmd   <= 1'b0;
          r_mem_addr  <= i_addr;
          r_mem_mask  <= 4'h0;
          r_mem_wdata <= 32'h0;
        end
      end else begin
        r_owner <= r_owner;
      end
    end
  end

  // Fetch starvation counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve <= '0;
    end else if (w_grant && !w_grant_d) begin
      r_starve <= '0;
    end else if (w_grant && i_req) begin
      if (r_starve != STARVE_LIM) begin
        r_starve <= r_starve + SW'(1);
      end else begin
        r_starve <= r_starve;
      end
    end else if ((r_state == S_IDLE) && !i_req) begin
      r_starve <= '0;
    end else begin
      r_starve <= r_starve;
    end
  end

  // Watchdog counter and sticky error flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tcnt <= '0;
      r_err  <= 1'b0;
    end else begin
      if ((r_state == S_WAIT) && !w_done && !w_tmo) begin
        r_tcnt <= r_tcnt + TW'(1);
      end else begin
        r_tcnt <= '0;
      end
      if (w_tmo) begin
        r_err <= 1'b1;
      end else begin
        r_err <= r_err;
      end
    end
  end

  // Completion: ready pulses and read-data capture for the owner
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_i_ready <= 1'b0;
      r_d_ready <= 1'b0;
      r_i_rdata <= 32'h0;
      r_d_rdata <= 32'h0;
    end else begin
      r_i_ready <= 1'b0;
      r_d_ready <= 1'b0;
      if (w_done || w_tmo) begin
        if (!r_owner) begin
          r_i_ready <= 1'b1;
          r_i_rdata <= w_tmo ? 32'h0 : mem_load_data;
        end else begin
          r_d_ready <= 1'b1;
          if (w_tmo) begin
            r_d_rdata <= 32'h0;
          end else if (!r_mem_cmd) begin
            r_d_rdata <= mem_load_data;
          end else begin
            r_d_rdata <= r_d_rdata;
          end
        end
      end
    end
  end

  assign i_ready        = r_i_ready;
  assign d_ready        = r_d_ready;
  assign i_rdata        = r_i_rdata;
  assign d_rdata        = r_d_rdata;
  assign mem_enable     = r_mem_enable;
  assign mem_cmd        = r_mem_cmd;
  assign mem_addr       = r_mem_addr;
  assign mem_mask       = r_mem_mask;
  assign mem_write_data = r_mem_wdata;
  assign err            = r_err;
  assign stall_if       = i_req & ~r_i_ready;
  assign stall_mem      = d_req & ~r_d_ready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter (STARVE_MAX = 4, TIMEOUT = 16).
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ready;
  logic        d_req;
  logic        d_cmd;
  logic [31:0] d_addr;
  logic [3:0]  d_mask;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic        mem_enable;
  logic        mem_cmd;
  logic [31:0] mem_addr;
  logic [3:0]  mem_mask;
  logic [31:0] mem_write_data;
  logic [31:0] mem_load_data;
  logic        mem_valid;
  logic        stall_if;
  logic        stall_mem;
  logic        err;

  int n_vec;
  int n_err;

  mem_port_arbiter #(.STARVE_MAX(4), .TIMEOUT(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_req          (i_req),
    .i_addr         (i_addr),
    .i_rdata        (i_rdata),
    .i_ready        (i_ready),
    .d_req          (d_req),
    .d_cmd          (d_cmd),
    .d_addr         (d_addr),
    .d_mask         (d_mask),
    .d_wdata        (d_wdata),
    .d_rdata        (d_rdata),
    .d_ready        (d_ready),
    .mem_enable     (mem_enable),
    .mem_cmd        (mem_cmd),
    .mem_addr       (mem_addr),
    .mem_mask       (mem_mask),
    .mem_write_data (mem_write_data),
    .mem_load_data  (mem_load_data),
    .mem_valid      (mem_valid),
    .stall_if       (stall_if),
    .stall_mem      (stall_mem),
    .err            (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step();
    step();
    n_vec++;
    if ({i_ready, d_ready, mem_enable, mem_cmd, mem_mask, stall_if, stall_mem} !== 10'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: got %b exp 0", {i_ready, d_ready, mem_enable, mem_cmd, mem_mask, stall_if, stall_mem});
    end
    n_vec++;
    if ({mem_addr, mem_write_data, i_rdata, d_rdata} !== 128'h0) begin
      n_err++;
      $display("FAIL reset_data: got %h exp 0", {mem_addr, mem_write_data, i_rdata, d_rdata});
    end
    n_vec++;
    if (err !== 1'b0) begin
      n_err++;
      $display("FAIL reset_err: got %b exp 0", err);
    end
    rst = 1'b0;
  endtask

  task automatic test_fetch;
    i_req = 1'b1;
    i_addr = 32'h100;
    #1;
    n_vec++;
    if (stall_if !== 1'b1) begin
      n_err++;
      $display("FAIL fetch_stall0: got %b exp 1", stall_if);
    end
    step();
    n_vec++;
    if ({mem_enable, mem_cmd, mem_mask, mem_addr} !== {1'b1, 1'b0, 4'h0, 32'h100}) begin
      n_err++;
      $display("FAIL fetch_issue: got %h exp %h", {mem_enable, mem_cmd, mem_mask, mem_addr}, {1'b1, 1'b0, 4'h0, 32'h100});
    end
    step();
    n_vec++;
    if (mem_enable !== 1'b0) begin
      n_err++;
      $display("FAIL fetch_en_pulse: got %b exp 0", mem_enable);
    end
    mem_valid = 1'b1;
    mem_load_data = 32'h00500093;
    step();
    mem_valid = 1'b0;
    n_vec++;
    if ({i_ready, i_rdata, stall_if} !== {1'b1, 32'h00500093, 1'b0}) begin
      n_err++;
      $display("FAIL fetch_resp: got %h exp %h", {i_ready, i_rdata, stall_if}, {1'b1, 32'h00500093, 1'b0});
    end
    i_req = 1'b0;
    step();
    n_vec++;
    if (i_ready !== 1'b0) begin
      n_err++;
      $display("FAIL fetch_ready_pulse: got %b exp 0", i_ready);
    end
  endtask

  task automatic test_both;
    logic exp_stall;
    for (int c = 0; c < 9; c++) begin
      case (c)
        0: begin
          i_req = 1'b1; i_addr = 32'h300;
          d_req = 1'b1; d_cmd = 1'b0; d_addr = 32'h200; d_mask = 4'h0; d_wdata = 32'h0;
        end
        2: begin mem_valid = 1'b1; mem_load_data = 32'h11111111; end
        6: begin mem_valid = 1'b1; mem_load_data = 32'h22222222; end
        default: mem_valid = 1'b0;
      endcase
      #1;
      exp_stall = (c <= 6) ? 1'b1 : 1'b0;
      n_vec++;
      if (stall_if !== exp_stall) begin
        n_err++;
        $display("FAIL both_stall_if c%0d: got %b exp %b", c, stall_if, exp_stall);
      end
      if (c == 1) begin
        n_vec++;
        if ({mem_enable, mem_addr} !== {1'b1, 32'h200}) begin
          n_err++;
          $display("FAIL both_data_first: got %h exp %h", {mem_enable, mem_addr}, {1'b1, 32'h200});
        end
      end
      if (c == 3) begin
        n_vec++;
        if ({d_ready, d_rdata, i_ready} !== {1'b1, 32'h11111111, 1'b0}) begin
          n_err++;
          $display("FAIL both_d_ready: got %h exp %h", {d_ready, d_rdata, i_ready}, {1'b1, 32'h11111111, 1'b0});
        end
        d_req = 1'b0;
      end
      if (c == 5) begin
        n_vec++;
        if ({mem_enable, mem_mask, mem_addr} !== {1'b1, 4'h0, 32'h300}) begin
          n_err++;
          $display("FAIL both_fetch_issue: got %h exp %h", {mem_enable, mem_mask, mem_addr}, {1'b1, 4'h0, 32'h300});
        end
      end
      if (c == 7) begin
        n_vec++;
        if ({i_ready, i_rdata} !== {1'b1, 32'h22222222}) begin
          n_err++;
          $display("FAIL both_i_ready: got %h exp %h", {i_ready, i_rdata}, {1'b1, 32'h22222222});
        end
        i_req = 1'b0;
      end
      step();
    end
  endtask

  task automatic test_write;
    logic [68:0] exp_f;
    exp_f = {1'b1, 4'b0011, 32'h40, 32'hDEADBEEF};
    for (int c = 0; c < 6; c++) begin
      if (c == 0) begin
        d_req = 1'b1; d_cmd = 1'b1; d_addr = 32'h40; d_mask = 4'b0011; d_wdata = 32'hDEADBEEF;
      end
      mem_valid = (c == 3) ? 1'b1 : 1'b0;
      mem_load_data = 32'hBAD0BAD0;
      #1;
      if (c >= 1 && c <= 3) begin
        n_vec++;
        if ({mem_cmd, mem_mask, mem_addr, mem_write_data} !== exp_f) begin
          n_err++;
          $display("FAIL write_fields c%0d: got %h exp %h", c, {mem_cmd, mem_mask, mem_addr, mem_write_data}, exp_f);
        end
        n_vec++;
        if (mem_enable !== ((c == 1) ? 1'b1 : 1'b0)) begin
          n_err++;
          $display("FAIL write_enable c%0d: got %b exp %b", c, mem_enable, (c == 1));
        end
      end
      if (c == 4) begin
        n_vec++;
        if ({d_ready, d_rdata} !== {1'b1, 32'h11111111}) begin
          n_err++;
          $display("FAIL write_resp: got %h exp %h", {d_ready, d_rdata}, {1'b1, 32'h11111111});
        end
        d_req = 1'b0;
      end
      if (c == 5) begin
        n_vec++;
        if (d_ready !== 1'b0) begin
          n_err++;
          $display("FAIL write_ready_pulse: got %b exp 0", d_ready);
        end
      end
      step();
    end
  endtask

  task automatic test_starve;
    logic [5:0] grants;
    logic       exp_g;
    logic       saw_en;
    int         n_g;
    grants = 6'b0;
    saw_en = 1'b0;
    n_g = 0;
    mem_load_data = 32'hA5A5A5A5;
    i_addr = 32'h500;
    d_addr = 32'h600; d_cmd = 1'b0; d_mask = 4'h0; d_wdata = 32'h0;
    i_req = 1'b1;
    d_req = 1'b1;
    for (int c = 0; c < 40; c++) begin
      // Memory model: completes one cycle after the enable strobe.
      mem_valid = saw_en;
      #1;
      saw_en = mem_enable;
      if (mem_enable) begin
        if (n_g < 6) grants[n_g] = (mem_addr == 32'h600);
        if (mem_addr == 32'h500) begin
          n_vec++;
          if (mem_mask !== 4'h0) begin
            n_err++;
            $display("FAIL starve_fetch_mask: got %h exp 0", mem_mask);
          end
        end
        n_g++;
      end
      if (i_ready) i_req = 1'b0;
      if (d_ready && n_g >= 6) d_req = 1'b0;
      step();
    end
    mem_valid = 1'b0;
    n_vec++;
    if (n_g !== 6) begin
      n_err++;
      $display("FAIL starve_grant_count: got %0d exp 6", n_g);
    end
    for (int k = 0; k < 6; k++) begin
      exp_g = (k == 4) ? 1'b0 : 1'b1;
      n_vec++;
      if (grants[k] !== exp_g) begin
        n_err++;
        $display("FAIL starve_grant%0d: got %s exp %s", k, grants[k] ? "D" : "I", exp_g ? "D" : "I");
      end
    end
  endtask

  task automatic run_read_wait(input logic [31:0] addr, input int valid_cycle,
                               output int rdy_c, output logic [31:0] rdata_at, output logic err_at);
    rdy_c = -1;
    rdata_at = 32'hFFFFFFFF;
    err_at = 1'bx;
    d_req = 1'b1; d_cmd = 1'b0; d_addr = addr; d_mask = 4'h0;
    for (int c = 0; c < 25; c++) begin
      mem_valid = (c == valid_cycle) ? 1'b1 : 1'b0;
      #1;
      if (d_ready && rdy_c < 0) begin
        rdy_c = c;
        rdata_at = d_rdata;
        err_at = err;
        d_req = 1'b0;
      end
      step();
    end
    mem_valid = 1'b0;
  endtask

  task automatic test_valid_vs_timeout;
    int r_c;
    logic [31:0] r_d;
    logic r_e;
    mem_load_data = 32'h12345678;
    run_read_wait(32'h90, 17, r_c, r_d, r_e);
    n_vec++;
    if (r_c !== 18) begin
      n_err++;
      $display("FAIL vvt_ready_cycle: got %0d exp 18", r_c);
    end
    n_vec++;
    if ({r_d, r_e} !== {32'h12345678, 1'b0}) begin
      n_err++;
      $display("FAIL vvt_data_err: got %h exp %h", {r_d, r_e}, {32'h12345678, 1'b0});
    end
  endtask

  task automatic test_timeout;
    int r_c;
    logic [31:0] r_d;
    logic r_e;
    mem_load_data = 32'h77777777;
    run_read_wait(32'h80, -1, r_c, r_d, r_e);
    n_vec++;
    if (r_c !== 18) begin
      n_err++;
      $display("FAIL tmo_ready_cycle: got %0d exp 18", r_c);
    end
    n_vec++;
    if ({r_d, r_e} !== {32'h0, 1'b1}) begin
      n_err++;
      $display("FAIL tmo_data_err: got %h exp %h", {r_d, r_e}, {32'h0, 1'b1});
    end
    step();
    step();
    n_vec++;
    if (err !== 1'b1) begin
      n_err++;
      $display("FAIL tmo_err_sticky: got %b exp 1", err);
    end
  endtask

  task automatic test_reset_mid;
    i_req = 1'b1;
    i_addr = 32'h700;
    step();
    step();
    // Now in WAIT for the fetch.
    rst = 1'b1;
    #1;
    n_vec++;
    if ({mem_enable, mem_addr, i_ready, i_rdata, d_rdata, err} !== 99'b0) begin
      n_err++;
      $display("FAIL rstmid_outputs: got %h exp 0", {mem_enable, mem_addr, i_ready, i_rdata, d_rdata, err});
    end
    i_req = 1'b0;
    step();
    rst = 1'b0;
    mem_valid = 1'b1;
    mem_load_data = 32'hCAFEF00D;
    for (int c = 0; c < 3; c++) begin
      step();
      mem_valid = 1'b0;
      n_vec++;
      if ({i_ready, d_ready, mem_enable} !== 3'b000) begin
        n_err++;
        $display("FAIL rstmid_no_ready c%0d: got %b exp 000", c, {i_ready, d_ready, mem_enable});
      end
    end
    // A fresh fetch must issue exactly one cycle later, proving IDLE.
    i_req = 1'b1;
    i_addr = 32'h104;
    step();
    n_vec++;
    if ({mem_enable, mem_addr} !== {1'b1, 32'h104}) begin
      n_err++;
      $display("FAIL rstmid_idle_issue: got %h exp %h", {mem_enable, mem_addr}, {1'b1, 32'h104});
    end
    step();
    mem_valid = 1'b1;
    mem_load_data = 32'h00A00113;
    step();
    mem_valid = 1'b0;
    n_vec++;
    if ({i_ready, i_rdata} !== {1'b1, 32'h00A00113}) begin
      n_err++;
      $display("FAIL rstmid_refetch: got %h exp %h", {i_ready, i_rdata}, {1'b1, 32'h00A00113});
    end
    i_req = 1'b0;
    step();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    i_req = 1'b0; i_addr = 32'h0;
    d_req = 1'b0; d_cmd = 1'b0; d_addr = 32'h0; d_mask = 4'h0; d_wdata = 32'h0;
    mem_load_data = 32'h0; mem_valid = 1'b0;
    test_reset();
    test_fetch();
    test_both();
    test_write();
    test_starve();
    test_valid_vs_timeout();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
